instr_fetch_unit: RTL and testbench

- Instruction-side producer for the RV32I core. Owns the PC, issues word reads to instruction memory and presents each fetched 32-bit word plus its PC on a valid/ready handshake.
- The decode stage (control unit) consumes instruction_code from this block.
- Supports a one-cycle redirect (branch/jump/trap) that flushes in-flight and buffered fetches.

---
 rtl/rv32i_pkg.sv | 25 ++
 rtl/ifetch_perf_cnt.sv | 36 +++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side types and constants.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Buffered instruction presented to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] code;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Fetch performance counters: accepted instructions and cycles spent waiting on memory.
module ifetch_perf_cnt
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] perf_fetch_cnt_o,
    output logic [XLEN-1:0] perf_stall_cnt_o
);

    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_i) fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        if (stall_i) stall_cnt_d = stall_cnt_q + XLEN'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: owns the PC, one outstanding imem read, valid/ready to decode.
// Define IFETCH_PERF_EN to add the perf_fetch_cnt/perf_stall_cnt counter outputs.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction_code,
    output logic [XLEN-1:0] instr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            valid_q, valid_d;
    fetch_pkt_t      pkt_q, pkt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            pkt_q   <= '{pc: '0, code: RV32I_NOP};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        valid_d   = valid_q;
        pkt_d     = pkt_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;

        unique case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        pkt_d   = '{pc: pc_q, code: imem_rdata};
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Issue the next fetch in the handshake cycle to hide one cycle of latency.
                if (instr_ready) begin
                    imem_req = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = WAIT;
                end
            end
            default: state_d = FETCH;
        endcase

        // Redirect overrides everything; an in-flight read is tagged for discard.
        if (redirect_valid) begin
            pc_d     = word_align(redirect_pc);
            valid_d  = 1'b0;
            pkt_d    = pkt_q;
            imem_req = 1'b0;
            if (state_q == WAIT && !imem_rvalid) begin
                kill_d  = 1'b1;
                state_d = WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = FETCH;
            end
        end

        if (rst) imem_req = 1'b0;
    end

    assign instr_valid      = valid_q;
    assign instruction_code = pkt_q.code;
    assign instr_pc         = pkt_q.pc;

`ifdef IFETCH_PERF_EN
    ifetch_perf_cnt u_perf (
        .clk              (clk),
        .rst              (rst),
        .fetch_i          (valid_q & instr_ready),
        .stall_i          (state_q == WAIT),
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
    );
`endif

    // A response is only legal while a request is outstanding; a late one right after reset is tolerated.
    a_rvalid_in_wait: assert property (
        @(posedge clk) disable iff (rst)
        imem_rvalid |-> ((state_q == WAIT) || $past(rst))
    ) else $error("imem_rvalid received outside WAIT");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: random ready/redirect/latency against a program-order PC model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction_code;
    logic [31:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    int unsigned m_stall = 0;
`endif

    int          checks   = 0;
    int          errors   = 0;
    int          hs_total = 0;
    int          lat_fixed;
    bit          stray_inject = 1'b0;
    bit          first_run    = 1'b1;
    int          mem_cnt      = 0;
    logic [31:0] mem_addr     = '0;
    logic [31:0] exp_q[$];
    logic [31:0] redir_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction_code (instruction_code),
        .instr_pc         (instr_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    // Instruction memory contents: a fixed word at 0, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_81B3;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: latency 1..3 cycles, flags a second outstanding request.
    initial begin
        logic        req_s;
        logic [31:0] addr_s;
        logic        rst_s;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            req_s  = imem_req;
            addr_s = imem_addr;
            rst_s  = rst;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (rst_s) begin
                mem_cnt = 0;
`ifdef IFETCH_PERF_EN
                m_stall = 0;
`endif
                if (stray_inject) begin
                    stray_inject = 1'b0;
                    imem_rvalid  = 1'b1;
                end
            end else begin
                if (req_s) begin
                    check32("one_outstanding", 32'(mem_cnt), 32'd0);
                    mem_cnt  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
                    mem_addr = addr_s;
                end
                if (mem_cnt > 0) begin
`ifdef IFETCH_PERF_EN
                    m_stall++;
`endif
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(mem_addr);
                    end
                end
            end
        end
    end

    // Monitor: pops the expected program-order PC on every handshake and checks handshake rules.
    initial begin
        logic        pv, pr, predir, prst;
        logic [31:0] pcode, ppc, tgt;
        int          cyc;
        pv = 1'b0; pr = 1'b0; predir = 1'b0; prst = 1'b0;
        pcode = '0; ppc = '0; cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prst) begin
                    check32("reset_valid", 32'(instr_valid), 32'd0);
                    check32("reset_code", instruction_code, NOP);
                    check32("reset_pc", instr_pc, 32'h0);
                    check32("reset_req", 32'(imem_req), 32'd0);
                end
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                hs_total = 0;
                pv = 1'b0; predir = 1'b0; prst = 1'b1; cyc = 0;
            end else begin
                if (cyc == 0) begin
                    check32("c0_req", 32'(imem_req), 32'd1);
                    check32("c0_addr", imem_addr, RESET_PC);
                    check32("c0_valid", 32'(instr_valid), 32'd0);
                    check32("c0_code", instruction_code, NOP);
`ifdef IFETCH_PERF_EN
                    check32("c0_perf_fetch", perf_fetch_cnt, 32'd0);
                    check32("c0_perf_stall", perf_stall_cnt, 32'd0);
`endif
                end
                if (cyc == 1) check32("c1_valid", 32'(instr_valid), 32'd0);
                if (first_run && cyc == 2) begin
                    check32("c2_valid", 32'(instr_valid), 32'd1);
                    check32("c2_pc", instr_pc, RESET_PC);
                    check32("c2_code", instruction_code, 32'h0020_81B3);
                end
                if (!prst && predir) check32("valid_after_redirect", 32'(instr_valid), 32'd0);
                if (!prst && pv && pr) check32("valid_after_handshake", 32'(instr_valid), 32'd0);
                if (!prst && pv && !pr && !predir) begin
                    check32("hold_valid", 32'(instr_valid), 32'd1);
                    check32("hold_code", instruction_code, pcode);
                    check32("hold_pc", instr_pc, ppc);
                end
                if (instr_valid && !instr_ready && !redirect_valid)
                    check32("no_req_in_hold", 32'(imem_req), 32'd0);
                if (instr_valid && instr_ready) begin
                    check32("hs_pc", instr_pc, exp_q[0]);
                    check32("hs_code", instruction_code, mem_word(exp_q[0]));
                    void'(exp_q.pop_front());
                    hs_total++;
                    if (!redirect_valid) begin
                        check32("hs_req", 32'(imem_req), 32'd1);
                        check32("hs_next_addr", imem_addr, 32'(instr_pc + 32'd4));
                    end
                end
                if (redirect_valid) begin
                    check32("redirect_req", 32'(imem_req), 32'd0);
                    if (redir_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL redir_sync: got redirect with no issued target");
                        tgt = redirect_pc;
                    end else begin
                        tgt = redir_q.pop_front();
                    end
                    exp_q.delete();
                    exp_q.push_back(tgt);
                end
                if (exp_q.size() == 0) exp_q.push_back(RESET_PC);
                while (exp_q.size() < 4) exp_q.push_back(32'(exp_q[exp_q.size() - 1] + 32'd4));
                pv = instr_valid; pr = instr_ready; predir = redirect_valid;
                pcode = instruction_code; ppc = instr_pc;
                prst = 1'b0;
                cyc++;
            end
        end
    end

    // Stimulus.
    initial begin
        logic [31:0] tgt;
        bit          found;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat_fixed      = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Hold the first instruction with ready low, then accept it.
        repeat (9) begin @(posedge clk); #1; end
        instr_ready = 1'b1;

        lat_fixed = 0;
        repeat (3000) begin
            @(posedge clk); #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
                    1:       tgt = 32'h0000_0103;
                    default: tgt = $urandom & 32'h0000_0FFF;
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                redir_q.push_back(tgt & ~32'h3);
            end else begin
                redirect_valid = 1'b0;
            end
        end

        // Pulse reset while a read is outstanding and inject a late response.
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        lat_fixed      = 3;
        found          = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #2;
            if (mem_cnt == 2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_outstanding: got no pending read within bound");
        end
        first_run    = 1'b0;
        stray_inject = 1'b1;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        lat_fixed = 1;
        repeat (20) begin @(posedge clk); #1; end

        instr_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (hs_total < 5) begin
            errors++;
            $display("FAIL progress: got %0d handshakes after reset expected at least 5", hs_total);
        end
`ifdef IFETCH_PERF_EN
        check32("perf_fetch_final", perf_fetch_cnt, 32'(hs_total));
        check32("perf_stall_final", perf_stall_cnt, 32'(m_stall));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
